// File: rtl/line_drawer_pkg.sv
// Shared types and constants for the line rasteriser.
package line_drawer_pkg;

  // Default screen coordinate width (coordinates 0..2047).
  localparam int COORD_W = 11;

  typedef logic [COORD_W-1:0]        coord_t;
  typedef logic signed [COORD_W+1:0] err_t;
  typedef logic signed [COORD_W+2:0] e2_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    RUN   = 2'd2
  } raster_state_e;

endpackage

// File: rtl/line_raster_core_step.sv
// One Bresenham walk step: given the current point and error term,
// produce the next point and error term. Purely combinational.
module bresenham_step
  import line_drawer_pkg::*;
#(
  parameter int W = COORD_W
) (
  input  logic [W-1:0]        i_x,
  input  logic [W-1:0]        i_y,
  input  logic signed [W+1:0] i_err,
  input  logic signed [W+1:0] i_dx,
  input  logic signed [W+1:0] i_dy,
  input  logic                i_sx_neg,
  input  logic                i_sy_neg,
  output logic [W-1:0]        o_x,
  output logic [W-1:0]        o_y,
  output logic signed [W+1:0] o_err
);

  localparam logic [W-1:0] ONE = W'(1);

  logic signed [W+2:0] w_e2;
  logic signed [W+2:0] w_dx_ext;
  logic signed [W+2:0] w_dy_ext;
  logic                w_step_x;
  logic                w_step_y;
  logic signed [W+1:0] w_err_dx_term;
  logic signed [W+1:0] w_err_dy_term;

  // e2 = 2*err; one extra bit so doubling can never overflow
  assign w_e2     = {i_err, 1'b0};
  assign w_dx_ext = {i_dx[W+1], i_dx};
  assign w_dy_ext = {i_dy[W+1], i_dy};

  // Both axis decisions use the same e2, so a diagonal step updates both
  assign w_step_x = (w_e2 >= w_dy_ext);
  assign w_step_y = (w_e2 <= w_dx_ext);

  assign o_x = w_step_x ? (i_sx_neg ? (i_x - ONE) : (i_x + ONE)) : i_x;
  assign o_y = w_step_y ? (i_sy_neg ? (i_y - ONE) : (i_y + ONE)) : i_y;

  assign w_err_dy_term = w_step_x ? i_dy : '0;
  assign w_err_dx_term = w_step_y ? i_dx : '0;
  assign o_err         = i_err + w_err_dy_term + w_err_dx_term;

endmodule

// File: rtl/line_raster_core.sv
// Bresenham line rasteriser: accepts one (x0,y0)->(x1,y1) command and
// streams every pixel of the line on a valid/ready interface.
//
//   state | meaning
//   ------+--------------------------------------------------------
//   IDLE  | waiting for a command; cmd_ready high (except 1st cycle
//         | after reset)
//   SETUP | one cycle: derive dx, dy, step directions, initial err
//   RUN   | presenting pixel (x,y); advance on each handshake
module line_raster_core #(
  parameter int COORD_W = line_drawer_pkg::COORD_W
) (
  input  logic               i_aclk,
  input  logic               i_areset,
  input  logic               i_cmd_valid,
  output logic               o_cmd_ready,
  input  logic [COORD_W-1:0] i_cmd_x0,
  input  logic [COORD_W-1:0] i_cmd_y0,
  input  logic [COORD_W-1:0] i_cmd_x1,
  input  logic [COORD_W-1:0] i_cmd_y1,
  input  logic               i_abort,
  output logic               o_pix_valid,
  input  logic               i_pix_ready,
  output logic [COORD_W-1:0] o_pix_x,
  output logic [COORD_W-1:0] o_pix_y,
  output logic               o_pix_last,
  output logic               o_busy,
  output logic               o_done_pulse
);

  import line_drawer_pkg::*;

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_SETUP = SETUP;
  localparam logic [1:0] S_RUN   = RUN;

  logic [1:0]                r_state;
  logic [1:0]                w_state_nxt;
  logic                      r_cmd_ready;
  logic                      r_done;

  // Current walk position; holds (x0,y0) between accept and SETUP
  logic [COORD_W-1:0]        r_x;
  logic [COORD_W-1:0]        r_y;
  logic [COORD_W-1:0]        r_x1;
  logic [COORD_W-1:0]        r_y1;
  logic signed [COORD_W+1:0] r_dx;
  logic signed [COORD_W+1:0] r_dy;
  logic signed [COORD_W+1:0] r_err;
  logic                      r_sx_neg;
  logic                      r_sy_neg;

  logic                      w_accept;
  logic                      w_run;
  logic                      w_last;
  logic                      w_hs;
  logic signed [COORD_W+1:0] w_dx_raw;
  logic signed [COORD_W+1:0] w_dy_raw;
  logic signed [COORD_W+1:0] w_dx_abs;
  logic signed [COORD_W+1:0] w_dy_abs;
  logic signed [COORD_W+1:0] w_dy_neg;
  logic signed [COORD_W+1:0] w_setup_err;
  logic [COORD_W-1:0]        w_x_step;
  logic [COORD_W-1:0]        w_y_step;
  logic signed [COORD_W+1:0] w_err_step;

  assign w_accept = (r_state == S_IDLE) && i_cmd_valid && r_cmd_ready;
  assign w_run    = (r_state == S_RUN);
  assign w_last   = (r_x == r_x1) && (r_y == r_y1);
  // abort wins over a same-cycle pixel handshake
  assign w_hs     = w_run && i_pix_ready && !i_abort;

  // Setup arithmetic: two guard bits keep the coordinate differences exact
  assign w_dx_raw    = $signed({2'b00, r_x1}) - $signed({2'b00, r_x});
  assign w_dy_raw    = $signed({2'b00, r_y1}) - $signed({2'b00, r_y});
  assign w_dx_abs    = w_dx_raw[COORD_W+1] ? -w_dx_raw : w_dx_raw;
  assign w_dy_abs    = w_dy_raw[COORD_W+1] ? -w_dy_raw : w_dy_raw;
  assign w_dy_neg    = -w_dy_abs;
  assign w_setup_err = w_dx_abs + w_dy_neg;

  bresenham_step #(
    .W (COORD_W)
  ) u_step (
    .i_x      (r_x),
    .i_y      (r_y),
    .i_err    (r_err),
    .i_dx     (r_dx),
    .i_dy     (r_dy),
    .i_sx_neg (r_sx_neg),
    .i_sy_neg (r_sy_neg),
    .o_x      (w_x_step),
    .o_y      (w_y_step),
    .o_err    (w_err_step)
  );

  // Next-state decode
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_accept) w_state_nxt = S_SETUP;
      end
      S_SETUP: begin
        w_state_nxt = i_abort ? S_IDLE : S_RUN;
      end
      S_RUN: begin
        if (i_abort || (i_pix_ready && w_last)) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // State and status flags; cmd_ready tracks "next state is IDLE" so it
  // stays low for the first cycle out of reset and returns with done_pulse
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_state     <= S_IDLE;
      r_cmd_ready <= 1'b0;
      r_done      <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd_ready <= (w_state_nxt == S_IDLE);
      r_done      <= w_hs && w_last;
    end
  end

  // Walk datapath: latch command, set up the error terms, then step
  always_ff @(posedge i_aclk or posedge i_areset) begin
    if (i_areset) begin
      r_x      <= '0;
      r_y      <= '0;
      r_x1     <= '0;
      r_y1     <= '0;
      r_dx     <= '0;
      r_dy     <= '0;
      r_err    <= '0;
      r_sx_neg <= 1'b0;
      r_sy_neg <= 1'b0;
    end else if (w_accept) begin
      r_x  <= i_cmd_x0;
      r_y  <= i_cmd_y0;
      r_x1 <= i_cmd_x1;
      r_y1 <= i_cmd_y1;
    end else if (r_state == S_SETUP) begin
      r_dx     <= w_dx_abs;
      r_dy     <= w_dy_neg;
      r_err    <= w_setup_err;
      r_sx_neg <= !(r_x < r_x1);
      r_sy_neg <= !(r_y < r_y1);
    end else if (w_hs && !w_last) begin
      r_x   <= w_x_step;
      r_y   <= w_y_step;
      r_err <= w_err_step;
    end
  end

  assign o_cmd_ready  = r_cmd_ready;
  assign o_pix_valid  = w_run;
  assign o_pix_x      = r_x;
  assign o_pix_y      = r_y;
  assign o_pix_last   = w_run && w_last;
  assign o_busy       = (r_state != S_IDLE);
  assign o_done_pulse = r_done;

endmodule

// File: tb/tb_line_raster_core.sv
// Testbench for line_raster_core: directed cases plus randomized lines,
// checked every cycle against a pixel-list model of the line.
`timescale 1ns/1ps
module tb_line_raster_core;

  localparam int CW = 11;

  logic          clk;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [CW-1:0] cmd_x0, cmd_y0, cmd_x1, cmd_y1;
  logic          abort;
  logic          pix_valid;
  logic          pix_ready;
  logic [CW-1:0] pix_x, pix_y;
  logic          pix_last;
  logic          busy;
  logic          done_pulse;

  line_raster_core #(.COORD_W(CW)) dut (
    .i_aclk       (clk),
    .i_areset     (rst),
    .i_cmd_valid  (cmd_valid),
    .o_cmd_ready  (cmd_ready),
    .i_cmd_x0     (cmd_x0),
    .i_cmd_y0     (cmd_y0),
    .i_cmd_x1     (cmd_x1),
    .i_cmd_y1     (cmd_y1),
    .i_abort      (abort),
    .o_pix_valid  (pix_valid),
    .i_pix_ready  (pix_ready),
    .o_pix_x      (pix_x),
    .o_pix_y      (pix_y),
    .o_pix_last   (pix_last),
    .o_busy       (busy),
    .o_done_pulse (done_pulse)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int n_err = 0;
  int n_chk = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- model: list of pixels the line must produce ----------
  int m_qx[$];
  int m_qy[$];
  int m_lead;
  bit m_done_next;
  bit m_fresh;
  int m_acc_cnt;
  int m_acc_cyc;
  int m_first_lat;
  bit m_want_first;
  int cyc;

  int cap_x[$];
  int cap_y[$];
  int cap_last;
  int cap_done;

  task automatic model_fill(input int x0, input int y0, input int x1, input int y1);
    int dx, dy, sx, sy, err, e2, x, y;
    dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy  = -((y1 > y0) ? y1 - y0 : y0 - y1);
    sx  = (x0 < x1) ? 1 : -1;
    sy  = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x   = x0;
    y   = y0;
    m_qx.delete();
    m_qy.delete();
    for (int n = 0; n < 5000; n++) begin
      m_qx.push_back(x);
      m_qy.push_back(y);
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
  endtask

  // ---------------- compare process: every negedge ----------------------
  bit run_now;
  bit fresh_now;
  int adx, ady;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk("rst_pix_valid", pix_valid, 0);
      chk("rst_cmd_ready", cmd_ready, 0);
      chk("rst_busy", busy, 0);
      chk("rst_done_pulse", done_pulse, 0);
      m_qx.delete();
      m_qy.delete();
      m_lead      = 0;
      m_done_next = 0;
      m_fresh     = 1;
    end else begin
      run_now   = (m_qx.size() > 0) && (m_lead == 0);
      fresh_now = m_fresh;
      m_fresh   = 0;
      chk("done_pulse", done_pulse, m_done_next);
      if (done_pulse) cap_done++;
      m_done_next = 0;
      if (run_now) begin
        chk("run_pix_valid", pix_valid, 1);
        chk("run_pix_x", pix_x, m_qx[0]);
        chk("run_pix_y", pix_y, m_qy[0]);
        chk("run_pix_last", pix_last, m_qx.size() == 1);
        chk("run_busy", busy, 1);
        chk("run_cmd_ready", cmd_ready, 0);
        if (m_want_first) begin
          m_first_lat  = cyc - m_acc_cyc;
          m_want_first = 0;
        end
      end else if (m_qx.size() > 0) begin
        chk("setup_pix_valid", pix_valid, 0);
        chk("setup_busy", busy, 1);
        chk("setup_cmd_ready", cmd_ready, 0);
        m_lead = 0;
      end else begin
        chk("idle_pix_valid", pix_valid, 0);
        chk("idle_busy", busy, 0);
        chk("idle_cmd_ready", cmd_ready, fresh_now ? 0 : 1);
      end
      // advance the model with this cycle's inputs
      if (m_qx.size() > 0) begin
        if (abort) begin
          m_qx.delete();
          m_qy.delete();
          m_lead = 0;
        end else if (run_now && pix_ready) begin
          cap_x.push_back(int'(pix_x));
          cap_y.push_back(int'(pix_y));
          if (pix_last) cap_last++;
          void'(m_qx.pop_front());
          void'(m_qy.pop_front());
          if (m_qx.size() == 0) m_done_next = 1;
        end
      end else if (cmd_valid && !fresh_now) begin
        model_fill(int'(cmd_x0), int'(cmd_y0), int'(cmd_x1), int'(cmd_y1));
        adx = (cmd_x1 > cmd_x0) ? int'(cmd_x1) - int'(cmd_x0) : int'(cmd_x0) - int'(cmd_x1);
        ady = (cmd_y1 > cmd_y0) ? int'(cmd_y1) - int'(cmd_y0) : int'(cmd_y0) - int'(cmd_y1);
        chk("model_pixel_count", m_qx.size(), ((adx > ady) ? adx : ady) + 1);
        m_lead       = 1;
        m_acc_cnt++;
        m_acc_cyc    = cyc;
        m_want_first = 1;
      end
    end
  end

  // ---------------- pix_ready driver ------------------------------------
  int rdy_mode = 0;
  int rdy_ph   = 0;

  initial begin
    pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (rdy_mode)
        1: begin
          pix_ready = ((rdy_ph % 3) == 0);
          rdy_ph++;
        end
        2: pix_ready = ($urandom_range(0, 3) != 0);
        default: pix_ready = 1'b1;
      endcase
    end
  end

  // ---------------- stimulus tasks (called at posedge+1) ----------------
  task automatic send_cmd(input int x0, input int y0, input int x1, input int y1);
    int start;
    start     = m_acc_cnt;
    cmd_x0    = x0[CW-1:0];
    cmd_y0    = y0[CW-1:0];
    cmd_x1    = x1[CW-1:0];
    cmd_y1    = y1[CW-1:0];
    cmd_valid = 1'b1;
    for (int k = 0; k < 6000 && m_acc_cnt == start; k++) begin
      @(posedge clk);
      #1;
    end
    chk("cmd_accepted", m_acc_cnt != start, 1);
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget && m_qx.size() > 0; k++) begin
      @(posedge clk);
      #1;
    end
    chk("line_finished", m_qx.size() == 0, 1);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_cap();
    cap_x.delete();
    cap_y.delete();
    cap_last = 0;
    cap_done = 0;
  endtask

  task automatic wait_cap(input int n);
    for (int k = 0; k < 200 && cap_x.size() < n; k++) begin
      @(posedge clk);
      #1;
    end
    chk("reached_pixel_count", cap_x.size(), n);
  endtask

  int t1x[5] = '{0, 1, 2, 3, 4};
  int t2x[6] = '{0, 1, 1, 2, 2, 3};
  int t2y[6] = '{0, 1, 2, 3, 4, 5};
  int t3x[5] = '{4, 3, 2, 1, 0};

  task automatic check_t2(input string tag);
    chk({tag, "_count"}, cap_x.size(), 6);
    for (int i = 0; i < 6 && i < cap_x.size(); i++) begin
      chk({tag, "_x"}, cap_x[i], t2x[i]);
      chk({tag, "_y"}, cap_y[i], t2y[i]);
    end
    chk({tag, "_last"}, cap_last, 1);
    chk({tag, "_done"}, cap_done, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int x0, y0, x1, y1, b, k;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_x0    = '0;
    cmd_y0    = '0;
    cmd_x1    = '0;
    cmd_y1    = '0;
    abort     = 1'b0;

    // pin the model itself against hand-derived sequences
    model_fill(0, 0, 3, 5);
    chk("model_t2_count", m_qx.size(), 6);
    for (int i = 0; i < 6 && i < m_qx.size(); i++) begin
      chk("model_t2_x", m_qx[i], t2x[i]);
      chk("model_t2_y", m_qy[i], t2y[i]);
    end
    model_fill(7, 7, 7, 7);
    chk("model_point_count", m_qx.size(), 1);
    m_qx.delete();
    m_qy.delete();

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;
    chk("ready_after_reset", cmd_ready, 1);

    // T1 horizontal
    rdy_mode = 0;
    clear_cap();
    send_cmd(0, 0, 4, 0);
    wait_idle(100);
    chk("t1_count", cap_x.size(), 5);
    for (int i = 0; i < 5 && i < cap_x.size(); i++) begin
      chk("t1_x", cap_x[i], t1x[i]);
      chk("t1_y", cap_y[i], 0);
    end
    chk("t1_last", cap_last, 1);
    chk("t1_done", cap_done, 1);

    // T2 steep
    clear_cap();
    send_cmd(0, 0, 3, 5);
    wait_idle(100);
    check_t2("t2");
    chk("t2_first_latency", m_first_lat, 2);

    // T3 reverse directions
    clear_cap();
    send_cmd(4, 2, 0, 2);
    wait_idle(100);
    chk("t3a_count", cap_x.size(), 5);
    for (int i = 0; i < 5 && i < cap_x.size(); i++) begin
      chk("t3a_x", cap_x[i], t3x[i]);
      chk("t3a_y", cap_y[i], 2);
    end
    clear_cap();
    send_cmd(0, 5, 0, 0);
    wait_idle(100);
    chk("t3b_count", cap_x.size(), 6);
    for (int i = 0; i < 6 && i < cap_x.size(); i++) begin
      chk("t3b_x", cap_x[i], 0);
      chk("t3b_y", cap_y[i], 5 - i);
    end

    // T4 single point
    clear_cap();
    send_cmd(7, 7, 7, 7);
    wait_idle(100);
    chk("t4_count", cap_x.size(), 1);
    if (cap_x.size() > 0) begin
      chk("t4_x", cap_x[0], 7);
      chk("t4_y", cap_y[0], 7);
    end
    chk("t4_last", cap_last, 1);
    chk("t4_done", cap_done, 1);

    // T5 backpressure 1,0,0,...
    rdy_mode = 1;
    rdy_ph   = 0;
    clear_cap();
    send_cmd(0, 0, 3, 5);
    wait_idle(200);
    check_t2("t5");
    rdy_mode = 0;

    // T6 abort after pixel 3, then a fresh command
    clear_cap();
    send_cmd(0, 0, 10, 3);
    wait_cap(3);
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    chk("t6_abort_pix_valid", pix_valid, 0);
    chk("t6_abort_busy", busy, 0);
    chk("t6_abort_done", done_pulse, 0);
    @(posedge clk);
    #1;
    chk("t6_abort_pixels", cap_x.size(), 3);
    chk("t6_abort_no_done", cap_done, 0);
    clear_cap();
    send_cmd(1, 1, 3, 2);
    wait_idle(100);
    chk("t6_after_abort_count", cap_x.size(), 3);
    chk("t6_after_abort_done", cap_done, 1);

    // T6 reset mid-line
    clear_cap();
    send_cmd(0, 0, 10, 3);
    wait_cap(3);
    rst = 1'b1;
    #1;
    chk("t6_rst_pix_valid", pix_valid, 0);
    chk("t6_rst_cmd_ready", cmd_ready, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_done", done_pulse, 0);
    chk("t6_rst_pix_x", pix_x, 0);
    chk("t6_rst_pix_y", pix_y, 0);
    chk("t6_rst_pix_last", pix_last, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // screen-corner lines
    clear_cap();
    send_cmd(2047, 2047, 0, 0);
    wait_idle(2200);
    chk("corner_diag_count", cap_x.size(), 2048);
    send_cmd(0, 2047, 2047, 1000);
    wait_idle(2200);

    // randomized lines, random backpressure, occasional abort / overlap
    rdy_mode = 2;
    for (int i = 0; i < 60; i++) begin
      b  = $urandom_range(0, 2007);
      x0 = b + $urandom_range(0, 40);
      x1 = b + $urandom_range(0, 40);
      b  = $urandom_range(0, 2007);
      y0 = b + $urandom_range(0, 40);
      y1 = b + $urandom_range(0, 40);
      send_cmd(x0, y0, x1, y1);
      if ($urandom_range(0, 7) == 0) begin
        k = $urandom_range(0, 30);
        repeat (k) @(posedge clk);
        #1 abort = 1'b1;
        @(posedge clk);
        #1 abort = 1'b0;
      end
      if ($urandom_range(0, 2) != 0) wait_idle(6000);
    end
    wait_idle(6000);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
